nibble_seq_detector: RTL and testbench

Streaming 4-bit sequence detector that sits directly downstream of the nibble equality comparator. Each accepted input nibble is compared for equality against one entry of a programmable DEPTH-nibble pattern. The block tracks the matched prefix with a small state machine, pulses `match` when the full pattern arrives, and keeps a saturating count of detections. It serves as the sequential consumer of per-nibble Equal results in lock, sync-word and test-pattern checks.

---
 rtl/nibble_seq_detector.sv | 127 ++++++++++++
 tb/tb_nibble_seq_detector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_seq_detector.sv
// ---------------------------------------------------------------------------
// nibble_seq_detector
//   Streaming 4-bit sequence detector. Each accepted nibble is compared with
//   one entry of a programmable DEPTH-nibble pattern. The block tracks the
//   matched prefix, pulses match when the whole pattern has arrived, and keeps
//   a saturating detection count.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   cfg_we      in   pattern write strobe (also restarts the scan)
//   cfg_addr    in   pattern entry to write; entries >= DEPTH are ignored
//   cfg_data    in   pattern nibble
//   clr         in   synchronous clear of match_count
//   in_valid    in   in_data is valid this cycle
//   in_data     in   stream nibble
//   match       out  one-cycle pulse after the final matching beat
//   busy        out  a partial prefix is held (progress != 0)
//   progress    out  current matched-prefix length
//   match_count out  saturating detection count
// ---------------------------------------------------------------------------
module nibble_seq_detector #(
  parameter  int DEPTH = 4,
  parameter  int CNT_W = 8,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [3:0]       cfg_data,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [3:0]       in_data,
  output logic             match,
  output logic             busy,
  output logic [IDX_W-1:0] progress,
  output logic [CNT_W-1:0] match_count
);

  // Saturating increment: the detection count sticks at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_W'(1);
    end
  endfunction

  logic [3:0]       r_pat [DEPTH];
  logic [IDX_W-1:0] r_idx;
  logic             r_match;
  logic [CNT_W-1:0] r_cnt;

  logic             w_addr_ok;
  logic             w_hit;
  logic             w_restart;
  logic             w_last;
  logic             w_detect;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next-state decode: configuration writes pre-empt the stream beat, and a
  // mismatch only restarts on pattern entry 0 (no deeper backtracking).
  always_comb begin
    w_addr_ok = ({1'b0, cfg_addr} < (IDX_W+1)'(DEPTH));
    w_hit     = in_valid && (in_data == r_pat[r_idx]);
    w_restart = (in_data == r_pat[0]);
    w_last    = (r_idx == IDX_W'(DEPTH - 1));
    w_detect  = !cfg_we && w_hit && w_last;
    w_idx_nxt = r_idx;
    if (cfg_we) begin
      w_idx_nxt = '0;
    end else if (w_hit) begin
      if (w_last) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1);
      end
    end else if (in_valid) begin
      if (w_restart) begin
        w_idx_nxt = IDX_W'(1);
      end else begin
        w_idx_nxt = '0;
      end
    end else begin
      w_idx_nxt = r_idx;
    end
    // A detection coinciding with clr survives the clear as a count of one.
    if (clr) begin
      if (w_detect) begin
        w_cnt_nxt = CNT_W'(1);
      end else begin
        w_cnt_nxt = '0;
      end
    end else if (w_detect) begin
      w_cnt_nxt = sat_inc(r_cnt);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // State, pattern storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pat[i] <= 4'h0;
      end
      r_idx   <= '0;
      r_match <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (cfg_we && w_addr_ok) begin
        r_pat[cfg_addr] <= cfg_data;
      end
      r_idx   <= w_idx_nxt;
      r_match <= w_detect;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign match       = r_match;
  assign busy        = (r_idx != '0);
  assign progress    = r_idx;
  assign match_count = r_cnt;

endmodule

// File: tb/tb_nibble_seq_detector.sv
module tb_nibble_seq_detector;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;
  localparam int IDX_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDX_W-1:0] cfg_addr = '0;
  logic [3:0]       cfg_data = 4'h0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic [3:0]       in_data = 4'h0;
  logic             match;
  logic             busy;
  logic [IDX_W-1:0] progress;
  logic [CNT_W-1:0] match_count;

  nibble_seq_detector #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .match(match), .busy(busy), .progress(progress), .match_count(match_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: prefix length as an integer, pattern as an array.
  int       m_pat [DEPTH];
  int       m_len;
  int       m_cnt;
  bit       m_match;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_pat[i] = 0;
    m_len = 0; m_cnt = 0; m_match = 0;
  endtask

  task automatic cmp(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check(input string tag);
    cmp({tag, ".match"}, int'(match), int'(m_match));
    cmp({tag, ".progress"}, int'(progress), m_len);
    cmp({tag, ".busy"}, int'(busy), (m_len != 0) ? 1 : 0);
    cmp({tag, ".count"}, int'(match_count), m_cnt);
  endtask

  // One clock: apply inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit we, input int a, input int dt,
                      input bit c, input bit v, input int d);
    bit det;
    cfg_we = we; cfg_addr = IDX_W'(a); cfg_data = 4'(dt);
    clr = c; in_valid = v; in_data = 4'(d);
    @(posedge clk); #1;
    det = 0;
    if (we) begin
      if (a < DEPTH) m_pat[a] = dt;
      m_len = 0;
    end else if (v) begin
      if (d == m_pat[m_len]) begin
        m_len = m_len + 1;
        if (m_len == DEPTH) begin
          det = 1;
          m_len = 0;
        end
      end else begin
        m_len = (d == m_pat[0]) ? 1 : 0;
      end
    end
    m_match = det;
    if (c) m_cnt = det ? 1 : 0;
    else if (det && m_cnt < CMAX) m_cnt = m_cnt + 1;
    check(tag);
    cfg_we = 1'b0; clr = 1'b0; in_valid = 1'b0;
  endtask

  task automatic beat(input string tag, input int d);
    step(tag, 0, 0, 0, 0, 1, d);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic program_pat(input int p0, input int p1, input int p2, input int p3);
    step("cfg0", 1, 0, p0, 0, 0, 0);
    step("cfg1", 1, 1, p1, 0, 0, 0);
    step("cfg2", 1, 2, p2, 0, 0, 0);
    step("cfg3", 1, 3, p3, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    // Reset held with in_valid toggling: everything stays zero.
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0]; in_data = 4'h0;
      @(posedge clk); #1;
      check("in_reset");
    end
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Default all-zero pattern: four zero beats give one detection.
    beat("dflt0", 0); beat("dflt1", 0); beat("dflt2", 0); beat("dflt3", 0);
    cmp("dflt_match_const", int'(match), 1);
    cmp("dflt_count_const", int'(match_count), 1);
    idle("dflt_after");

    // Basic detect.
    program_pat(3, 10, 5, 15);
    beat("basic0", 3); beat("basic1", 10); beat("basic2", 5); beat("basic3", 15);
    cmp("basic_count_const", int'(match_count), 2);
    idle("basic_after");

    // Mismatch restart.
    beat("mr0", 3); beat("mr1", 10); beat("mr2", 3); beat("mr3", 10);
    beat("mr4", 5); beat("mr5", 15);
    beat("rr0", 3); beat("rr1", 3); beat("rr2", 10); beat("rr3", 5); beat("rr4", 15);
    cmp("restart_count_sat", int'(match_count), 3);

    // Gaps between beats.
    clr = 1'b1; idle("clr_idle");
    beat("gap0", 3); idle("g"); idle("g");
    beat("gap1", 10); idle("g"); idle("g");
    beat("gap2", 5); idle("g"); idle("g");
    beat("gap3", 15);
    cmp("gap_match_const", int'(match), 1);

    // Configuration write alongside the final beat drops it.
    beat("pri0", 3); beat("pri1", 10); beat("pri2", 5);
    step("pri3", 1, 3, 15, 0, 1, 15);
    cmp("pri_nomatch_const", int'(match), 0);
    idle("pri_after");

    // Counter saturation, then clr coinciding with a detection.
    for (int k = 0; k < 5; k++) begin
      beat("sat", 3); beat("sat", 10); beat("sat", 5); beat("sat", 15);
    end
    beat("clrdet0", 3); beat("clrdet1", 10); beat("clrdet2", 5);
    step("clrdet3", 0, 0, 0, 1, 1, 15);
    cmp("clrdet_const", int'(match_count), 1);

    // Asynchronous reset mid-sequence.
    beat("ar0", 3); beat("ar1", 10); beat("ar2", 5);
    rst_n = 1'b0;
    #2;
    model_reset();
    check("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    beat("ar_f", 15);
    idle("ar_after");

    // Randomized traffic over a small alphabet so detections are frequent.
    program_pat($urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
    for (int n = 0; n < 1500; n++) begin
      bit we, c, v;
      we = ($urandom_range(0, 99) < 3);
      c  = ($urandom_range(0, 99) < 5);
      v  = ($urandom_range(0, 99) < 80);
      step("rand", we, $urandom_range(0, DEPTH - 1), $urandom_range(0, 3),
           c, v, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
